// File: rtl/pong_pkg.sv
// Shared types and field constants for the Pong game controller slice.
package pong_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVE,
    S_PLAY,
    S_POINT,
    S_OVER
  } state_e;

  localparam int FIELD_W    = 64;
  localparam int CENTRE     = 32;
  localparam int PADDLE_L_X = 2;
  localparam int PADDLE_R_X = 61;
  localparam int PADDLE_H   = 6;

  // serve_dir encodings: P1 sits on the -x side, P2 on the +x side
  localparam logic SERVE_P1 = 1'b0;
  localparam logic SERVE_P2 = 1'b1;

  localparam logic PLAYER1 = 1'b0;
  localparam logic PLAYER2 = 1'b1;

endpackage

// File: rtl/pong_score_cnt.sv
// Saturating score register with synchronous clear; one instance per player.
module pong_score_cnt #(
  parameter int SCORE_W = 4,
  parameter int SAT     = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [SCORE_W-1:0] score_o
);

  localparam logic [SCORE_W-1:0] SatVal = SCORE_W'(SAT);

  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_d;

  always_comb begin
    score_d = score_q;
    if (clr_i) begin
      score_d = '0;
    end else if (inc_i && (score_q != SatVal)) begin
      score_d = score_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score_o = score_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/play/point/over flow, ball strobes and both scores.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_TICKS = 60,
  parameter int SCORE_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_i,
  input  logic               start_i,
  input  logic               pause_i,
  input  logic               paddle_hit_i,
  input  logic               wall_hit_i,
  input  logic               miss_l_i,
  input  logic               miss_r_i,
  output logic               ball_rst_o,
  output logic               ball_step_o,
  output logic               flip_x_o,
  output logic               flip_y_o,
  output logic               serve_dir_o,
  output logic [SCORE_W-1:0] score1_o,
  output logic [SCORE_W-1:0] score2_o,
  output logic               game_over_o,
  output logic               winner_o
);

  localparam logic [7:0]         CntLast   = 8'(SERVE_TICKS - 1);
  localparam logic [SCORE_W-1:0] ScoreLast = SCORE_W'(WIN_SCORE - 1);

  state_e     state_q;
  logic [7:0] cnt_q;
  logic       scorer_q;
  logic       ball_rst_q;
  logic       step_q;
  logic       flip_x_q;
  logic       flip_y_q;
  logic       serve_dir_q;
  logic       game_over_q;
  logic       winner_q;

  logic clr_scores;
  logic inc1;
  logic inc2;
  logic win_point;

  assign clr_scores = start_i && ((state_q == S_IDLE) || (state_q == S_OVER));
  assign inc1       = (state_q == S_POINT) && (scorer_q == PLAYER1);
  assign inc2       = (state_q == S_POINT) && (scorer_q == PLAYER2);
  // The increment lands on the same edge that leaves POINT, so test the pre-increment value
  assign win_point  = (scorer_q == PLAYER1) ? (score1_o == ScoreLast)
                                            : (score2_o == ScoreLast);

  pong_score_cnt #(.SCORE_W(SCORE_W), .SAT(WIN_SCORE)) u_score1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr_scores),
    .inc_i   (inc1),
    .score_o (score1_o)
  );

  pong_score_cnt #(.SCORE_W(SCORE_W), .SAT(WIN_SCORE)) u_score2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr_scores),
    .inc_i   (inc2),
    .score_o (score2_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      scorer_q    <= PLAYER1;
      ball_rst_q  <= 1'b1;
      step_q      <= 1'b0;
      flip_x_q    <= 1'b0;
      flip_y_q    <= 1'b0;
      serve_dir_q <= SERVE_P2;
      game_over_q <= 1'b0;
      winner_q    <= PLAYER1;
    end else begin
      step_q   <= 1'b0;
      flip_x_q <= 1'b0;
      flip_y_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            serve_dir_q <= SERVE_P2;
            cnt_q       <= '0;
            state_q     <= S_SERVE;
          end
        end
        S_SERVE: begin
          if (tick_i) begin
            if (cnt_q == CntLast) begin
              cnt_q      <= '0;
              ball_rst_q <= 1'b0;
              state_q    <= S_PLAY;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        S_PLAY: begin
          if (tick_i && !pause_i) begin
            if (miss_l_i) begin
              scorer_q   <= PLAYER2;
              ball_rst_q <= 1'b1;
              state_q    <= S_POINT;
            end else if (miss_r_i) begin
              scorer_q   <= PLAYER1;
              ball_rst_q <= 1'b1;
              state_q    <= S_POINT;
            end else begin
              step_q   <= 1'b1;
              flip_x_q <= paddle_hit_i;
              flip_y_q <= wall_hit_i;
            end
          end
        end
        S_POINT: begin
          serve_dir_q <= (scorer_q == PLAYER2) ? SERVE_P1 : SERVE_P2;
          if (win_point) begin
            winner_q    <= scorer_q;
            game_over_q <= 1'b1;
            state_q     <= S_OVER;
          end else begin
            cnt_q   <= '0;
            state_q <= S_SERVE;
          end
        end
        S_OVER: begin
          if (start_i) begin
            game_over_q <= 1'b0;
            serve_dir_q <= SERVE_P2;
            cnt_q       <= '0;
            state_q     <= S_SERVE;
          end
        end
        default: begin
          ball_rst_q <= 1'b1;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign ball_rst_o  = ball_rst_q;
  assign ball_step_o = step_q;
  assign flip_x_o    = flip_x_q;
  assign flip_y_o    = flip_y_q;
  assign serve_dir_o = serve_dir_q;
  assign game_over_o = game_over_q;
  assign winner_o    = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: stimulus queues expected events, a monitor pops them.
module tb_pong_game_ctrl;

  localparam int WIN = 3;
  localparam int ST  = 4;
  localparam int SW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          tick = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          paddle = 1'b0;
  logic          wall = 1'b0;
  logic          missL = 1'b0;
  logic          missR = 1'b0;
  logic          ballRst;
  logic          ballStep;
  logic          flipX;
  logic          flipY;
  logic          serveDir;
  logic [SW-1:0] score1;
  logic [SW-1:0] score2;
  logic          gameOver;
  logic          winner;

  typedef struct packed {
    logic          kind;
    logic          step;
    logic          fx;
    logic          fy;
    logic [SW-1:0] s1;
    logic [SW-1:0] s2;
    logic          go;
    logic          win;
    logic          sdir;
  } event_t;

  event_t        expQ[$];
  int            compared = 0;
  int            mismatched = 0;
  logic [SW-1:0] prevS1 = '0;
  logic [SW-1:0] prevS2 = '0;
  logic          prevGo = 1'b0;

  pong_game_ctrl #(.WIN_SCORE(WIN), .SERVE_TICKS(ST), .SCORE_W(SW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_i       (tick),
    .start_i      (start),
    .pause_i      (pause),
    .paddle_hit_i (paddle),
    .wall_hit_i   (wall),
    .miss_l_i     (missL),
    .miss_r_i     (missR),
    .ball_rst_o   (ballRst),
    .ball_step_o  (ballStep),
    .flip_x_o     (flipX),
    .flip_y_o     (flipY),
    .serve_dir_o  (serveDir),
    .score1_o     (score1),
    .score2_o     (score2),
    .game_over_o  (gameOver),
    .winner_o     (winner)
  );

  always #5 clk = ~clk;

  task automatic checkEvent(input logic kind);
    event_t act;
    event_t e;
    act = '0;
    act.kind = kind;
    if (kind == 1'b0) begin
      act.step = ballStep;
      act.fx   = flipX;
      act.fy   = flipY;
    end else begin
      act.s1   = score1;
      act.s2   = score2;
      act.go   = gameOver;
      act.win  = winner;
      act.sdir = serveDir;
    end
    compared++;
    if (expQ.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL unexpected_event at %0t: actual %h required none", $time, act);
    end else begin
      e = expQ.pop_front();
      if (e !== act) begin
        mismatched++;
        $display("[TB] FAIL event at %0t: actual kind=%0b step=%0b fx=%0b fy=%0b s1=%0d s2=%0d go=%0b win=%0b sdir=%0b required kind=%0b step=%0b fx=%0b fy=%0b s1=%0d s2=%0d go=%0b win=%0b sdir=%0b",
                 $time, act.kind, act.step, act.fx, act.fy, act.s1, act.s2, act.go, act.win, act.sdir,
                 e.kind, e.step, e.fx, e.fy, e.s1, e.s2, e.go, e.win, e.sdir);
      end
    end
  endtask

  // Monitor: any strobe or any change in score/game_over is a DUT event to account for
  always @(negedge clk) begin
    if ((ballStep | flipX | flipY) === 1'b1) checkEvent(1'b0);
    if ((score1 !== prevS1) || (score2 !== prevS2) || (gameOver !== prevGo)) checkEvent(1'b1);
    prevS1 = score1;
    prevS2 = score2;
    prevGo = gameOver;
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic pushStep(input logic fx, input logic fy);
    event_t e;
    e = '0;
    e.step = 1'b1;
    e.fx   = fx;
    e.fy   = fy;
    expQ.push_back(e);
  endtask

  task automatic pushScore(input int s1, input int s2, input logic go, input logic win, input logic sdir);
    event_t e;
    e = '0;
    e.kind = 1'b1;
    e.s1   = SW'(s1);
    e.s2   = SW'(s2);
    e.go   = go;
    e.win  = win;
    e.sdir = sdir;
    expQ.push_back(e);
  endtask

  // One frame tick with the given flags, followed by a quiet cycle; call on a negedge
  task automatic applyStimulus(input logic ml, input logic mr, input logic ph, input logic wh);
    tick   = 1'b1;
    missL  = ml;
    missR  = mr;
    paddle = ph;
    wall   = wh;
    @(negedge clk);
    tick   = 1'b0;
    missL  = 1'b0;
    missR  = 1'b0;
    paddle = 1'b0;
    wall   = 1'b0;
    @(negedge clk);
  endtask

  task automatic playTick(input logic ph, input logic wh);
    pushStep(ph, wh);
    applyStimulus(1'b0, 1'b0, ph, wh);
  endtask

  task automatic serveSeq();
    for (int i = 0; i < ST - 1; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("serve_ball_rst", 8'(ballRst), 8'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("play_ball_rst", 8'(ballRst), 8'd0);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ball_rst", 8'(ballRst), 8'd1);
    checkOutput("rst_strobes", 8'({ballStep, flipX, flipY}), 8'd0);
    checkOutput("rst_serve_dir", 8'(serveDir), 8'd1);
    checkOutput("rst_scores", 8'({score1, score2}), 8'd0);
    checkOutput("rst_game_over", 8'(gameOver), 8'd0);
    checkOutput("rst_winner", 8'(winner), 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] serve and normal play");
    pulseStart();
    checkOutput("idle_to_serve_ball_rst", 8'(ballRst), 8'd1);
    serveSeq();
    checkOutput("first_serve_dir", 8'(serveDir), 8'd1);
    repeat (3) playTick(1'b0, 1'b0);
    playTick(1'b1, 1'b1);
    playTick(1'b1, 1'b0);
    playTick(1'b0, 1'b1);
    start = 1'b1;
    playTick(1'b0, 1'b0);
    start = 1'b0;

    $display("[TB] miss_l point");
    pushScore(0, 1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("point_ball_rst", 8'(ballRst), 8'd1);
    checkOutput("serve_dir_after_p2", 8'(serveDir), 8'd0);
    serveSeq();

    $display("[TB] pause");
    pause = 1'b1;
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    pause = 1'b0;
    checkOutput("pause_score2", 8'(score2), 8'd1);
    checkOutput("pause_ball_rst", 8'(ballRst), 8'd0);
    playTick(1'b0, 1'b0);

    $display("[TB] reach 2:1 then reset mid-play");
    pushScore(1, 1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    serveSeq();
    pushScore(2, 1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    serveSeq();
    playTick(1'b1, 1'b0);
    pushScore(0, 0, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_ball_rst", 8'(ballRst), 8'd1);
    checkOutput("midrst_strobes", 8'({ballStep, flipX, flipY}), 8'd0);
    checkOutput("midrst_scores", 8'({score1, score2}), 8'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] full game, player 1 wins");
    pulseStart();
    serveSeq();
    pushScore(1, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    serveSeq();
    pushScore(1, 1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    serveSeq();
    pushScore(2, 1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    serveSeq();
    pushScore(3, 1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("over_game_over", 8'(gameOver), 8'd1);
    checkOutput("over_winner", 8'(winner), 8'd0);
    checkOutput("over_ball_rst", 8'(ballRst), 8'd1);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("over_score1_frozen", 8'(score1), 8'd3);

    $display("[TB] restart, player 2 wins");
    pushScore(0, 0, 1'b0, 1'b0, 1'b1);
    pulseStart();
    checkOutput("restart_game_over", 8'(gameOver), 8'd0);
    serveSeq();
    pushScore(0, 1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    serveSeq();
    pushScore(0, 2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    serveSeq();
    pushScore(0, 3, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("p2_winner", 8'(winner), 8'd1);
    checkOutput("p2_game_over", 8'(gameOver), 8'd1);

    repeat (3) @(negedge clk);
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL pending_events: actual %0d required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
